// File: rtl/div_hilo_if.sv
// Control-unit side of the HI/LO divide stage: divide request, direct HI/LO writes, status and results.
interface div_hilo_if #(
   parameter int BITS = 32
);
   logic                   start;
   logic signed [BITS-1:0] dividend_in;
   logic signed [BITS-1:0] divisor_in;
   logic                   hi_write;
   logic                   lo_write;
   logic [BITS-1:0]        write_data;
   logic                   busy;
   logic                   done;
   logic                   div_zero;
   logic [BITS-1:0]        hi_out;
   logic [BITS-1:0]        lo_out;

   modport master (
      output start, dividend_in, divisor_in, hi_write, lo_write, write_data,
      input  busy, done, div_zero, hi_out, lo_out
   );

   modport slave (
      input  start, dividend_in, divisor_in, hi_write, lo_write, write_data,
      output busy, done, div_zero, hi_out, lo_out
   );
endinterface

// File: rtl/div_hilo_unit.sv
// Sequential HI/LO stage around a combinational array divider: registers operands, waits SETTLE_CYCLES, captures.
// Optional macro DIV_HILO_ZERO_TRAP_EN: zero divisor completes in one cycle with LO=all ones, HI=dividend, div_zero=1.
module div_hilo_unit #(
   parameter int BITS          = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic            clk,
   input  logic            clr,
   div_hilo_if.slave       bus,
   output logic [BITS-1:0] div_dividend,
   output logic [BITS-1:0] div_divisor,
   input  logic [BITS-1:0] div_quotient,
   input  logic [BITS-1:0] div_remainder
);

   localparam int CW = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   count;
   logic            accept;
   logic            capture;
   logic            trap_hit;
   logic [BITS-1:0] hi_q;
   logic [BITS-1:0] lo_q;
   logic            zero_q;
   logic            busy_c;
   logic            done_c;

   // DONE behaves as IDLE for new requests; only SETTLE locks the unit.
   assign accept  = bus.start && (state != SETTLE);
   assign capture = (state == SETTLE) && (count == '0);

`ifdef DIV_HILO_ZERO_TRAP_EN
   assign trap_hit = accept && (bus.divisor_in == '0);
`else
   assign trap_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      case (state)
         IDLE, DONE: begin
            done_c = (state == DONE);
            if (accept) begin
               state_next = trap_hit ? DONE : SETTLE;
            end else begin
               state_next = IDLE;
            end
         end
         SETTLE: begin
            busy_c = 1'b1;
            if (count == '0) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         count <= '0;
      end else if (accept) begin
         count <= CW'(SETTLE_CYCLES - 1);
      end else if ((state == SETTLE) && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   // Operands only move on an accepted start, so the divider inputs are stable for the whole settle window.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         div_dividend <= '0;
         div_divisor  <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         zero_q       <= 1'b0;
      end else if (accept) begin
         div_dividend <= bus.dividend_in;
         div_divisor  <= bus.divisor_in;
         zero_q       <= 1'b0;
         if (trap_hit) begin
            lo_q   <= '1;
            hi_q   <= bus.dividend_in;
            zero_q <= 1'b1;
         end
      end else if (capture) begin
         lo_q <= div_quotient;
         hi_q <= div_remainder;
      end else if (state != SETTLE) begin
         if (bus.hi_write) hi_q <= bus.write_data;
         if (bus.lo_write) lo_q <= bus.write_data;
      end
   end

   assign bus.busy     = busy_c;
   assign bus.done     = done_c;
   assign bus.div_zero = zero_q;
   assign bus.hi_out   = hi_q;
   assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Bench for div_hilo_unit: behavioural divider and HI/LO model, per-cycle compare, directed and random stimulus.
module tb_div_hilo_unit;
   localparam int BITS = 32;
   localparam int S    = 4;

   logic            clk;
   logic            clr;
   logic [BITS-1:0] div_dividend;
   logic [BITS-1:0] div_divisor;
   logic [BITS-1:0] div_quotient;
   logic [BITS-1:0] div_remainder;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   div_hilo_if #(.BITS(BITS)) bus ();

   div_hilo_unit #(.BITS(BITS), .SETTLE_CYCLES(S)) dut (
      .clk          (clk),
      .clr          (clr),
      .bus          (bus),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_quotient (div_quotient),
      .div_remainder(div_remainder)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Divider with C semantics; zero divisor and overflow given fixed, defined answers.
   function automatic logic [31:0] div_q(input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a; sb = b;
      if (b == 0) return 32'hFFFF_FFFF;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
      return 32'(sa / sb);
   endfunction

   function automatic logic [31:0] div_r(input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a; sb = b;
      if (b == 0) return a;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
      return 32'(sa % sb);
   endfunction

   assign div_quotient  = div_q(div_dividend, div_divisor);
   assign div_remainder = div_r(div_dividend, div_divisor);

   // Reference model: a pending result that lands S edges after the accepted start.
   logic [31:0] m_hi, m_lo, m_dd, m_dv, p_q, p_r;
   bit          m_busy, m_done, m_zero;
   int          left;

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         m_hi = 0; m_lo = 0; m_dd = 0; m_dv = 0;
         m_busy = 0; m_done = 0; m_zero = 0; left = 0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            left = left - 1;
            if (left == 0) begin
               m_busy = 0; m_done = 1; m_lo = p_q; m_hi = p_r;
            end
         end else if (bus.start) begin
            m_dd = bus.dividend_in; m_dv = bus.divisor_in; m_zero = 0;
            p_q = div_q(m_dd, m_dv); p_r = div_r(m_dd, m_dv);
            m_busy = 1; left = S;
`ifdef DIV_HILO_ZERO_TRAP_EN
            if (m_dv == 0) begin
               m_busy = 0; m_done = 1; m_zero = 1;
               m_lo = 32'hFFFF_FFFF; m_hi = m_dd;
            end
`endif
         end else begin
            if (bus.hi_write) m_hi = bus.write_data;
            if (bus.lo_write) m_lo = bus.write_data;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (cmp_en) begin
         check("busy", 32'(bus.busy), 32'(m_busy));
         check("done", 32'(bus.done), 32'(m_done));
         check("div_zero", 32'(bus.div_zero), 32'(m_zero));
         check("hi_out", bus.hi_out, m_hi);
         check("lo_out", bus.lo_out, m_lo);
         check("div_dividend", div_dividend, m_dd);
         check("div_divisor", div_divisor, m_dv);
      end
   end

   task automatic idle_inputs();
      bus.start = 0; bus.hi_write = 0; bus.lo_write = 0;
   endtask

   // Waits for done (bounded), counting busy cycles seen on the way.
   task automatic wait_done(output int busy_cnt, output bit seen);
      busy_cnt = 0; seen = 0;
      for (int n = 0; n < 40; n++) begin
         if (bus.done) begin seen = 1; break; end
         if (bus.busy) busy_cnt++;
         @(negedge clk);
      end
      check("done_within_bound", 32'(seen), 32'd1);
   endtask

   task automatic run_div(input string tag, input int a, input int b, input int eq, input int er);
      int  bc;
      bit  seen;
      @(negedge clk);
      bus.start = 1; bus.dividend_in = a; bus.divisor_in = b;
      @(negedge clk);
      bus.start = 0;
      wait_done(bc, seen);
      check({tag, "_busy_cycles"}, 32'(bc), 32'(S));
      check({tag, "_lo"}, bus.lo_out, 32'(eq));
      check({tag, "_hi"}, bus.hi_out, 32'(er));
      check({tag, "_model_lo"}, m_lo, 32'(eq));
      check({tag, "_model_hi"}, m_hi, 32'(er));
      @(negedge clk);
      check({tag, "_done_cleared"}, 32'(bus.done), 32'd0);
      check({tag, "_busy_cleared"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int  bc;
      bit  seen;
      int  dones;
      clr = 0;
      idle_inputs();
      bus.dividend_in = 0; bus.divisor_in = 0; bus.write_data = 0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_hi", bus.hi_out, 32'd0);
      check("rst_lo", bus.lo_out, 32'd0);
      check("rst_div_dividend", div_dividend, 32'd0);
      clr = 1;
      cmp_en = 1;

      run_div("basic", 97, 7, 13, 6);
      run_div("neg_dividend", -97, 7, -13, -6);
      run_div("neg_divisor", 97, -7, -13, 6);

      // Requests during SETTLE are dropped.
      @(negedge clk);
      bus.start = 1; bus.dividend_in = 1000; bus.divisor_in = 3;
      @(negedge clk);
      bus.start = 0;
      check("ign_dividend_a", div_dividend, 32'd1000);
      @(negedge clk);
      bus.start = 1; bus.dividend_in = 5; bus.divisor_in = 5;
      bus.hi_write = 1; bus.write_data = 32'hDEAD;
      @(negedge clk);
      idle_inputs();
      check("ign_dividend_b", div_dividend, 32'd1000);
      wait_done(bc, seen);
      check("ign_dividend_c", div_dividend, 32'd1000);
      check("ign_lo", bus.lo_out, 32'd333);
      check("ign_hi", bus.hi_out, 32'd1);

      // Back-to-back: start in the DONE cycle.
      @(negedge clk);
      bus.start = 1; bus.dividend_in = 20; bus.divisor_in = 6;
      @(negedge clk);
      bus.start = 0;
      wait_done(bc, seen);
      check("b2b_first_lo", bus.lo_out, 32'd3);
      bus.start = 1; bus.dividend_in = 50; bus.divisor_in = 8;
      @(negedge clk);
      bus.start = 0;
      check("b2b_done_one_cycle", 32'(bus.done), 32'd0);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      wait_done(bc, seen);
      check("b2b_busy_cycles", 32'(bc), 32'(S));
      check("b2b_lo", bus.lo_out, 32'd6);
      check("b2b_hi", bus.hi_out, 32'd2);

      // Reset two cycles into SETTLE.
      @(negedge clk);
      bus.start = 1; bus.dividend_in = 97; bus.divisor_in = 7;
      @(negedge clk);
      bus.start = 0;
      @(negedge clk);
      clr = 0;
      #1;
      check("abort_hi", bus.hi_out, 32'd0);
      check("abort_lo", bus.lo_out, 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      clr = 1;
      dones = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      check("abort_no_done", 32'(dones), 32'd0);
      bus.hi_write = 1; bus.lo_write = 1; bus.write_data = 32'h1234;
      @(negedge clk);
      idle_inputs();
      check("wr_both_hi", bus.hi_out, 32'h1234);
      check("wr_both_lo", bus.lo_out, 32'h1234);

      // Zero divisor.
      @(negedge clk);
      bus.start = 1; bus.dividend_in = 42; bus.divisor_in = 0;
      @(negedge clk);
      bus.start = 0;
`ifdef DIV_HILO_ZERO_TRAP_EN
      check("trap_done", 32'(bus.done), 32'd1);
      check("trap_lo", bus.lo_out, 32'hFFFF_FFFF);
      check("trap_hi", bus.hi_out, 32'd42);
      check("trap_zero", 32'(bus.div_zero), 32'd1);
      @(negedge clk);
      bus.start = 1; bus.dividend_in = 10; bus.divisor_in = 3;
      @(negedge clk);
      bus.start = 0;
      check("trap_zero_cleared", 32'(bus.div_zero), 32'd0);
      wait_done(bc, seen);
      check("after_trap_lo", bus.lo_out, 32'd3);
`else
      check("zero_busy", 32'(bus.busy), 32'd1);
      wait_done(bc, seen);
      check("zero_lo", bus.lo_out, 32'hFFFF_FFFF);
      check("zero_hi", bus.hi_out, 32'd42);
      check("zero_flag_tied", 32'(bus.div_zero), 32'd0);
`endif

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         clr = ($urandom_range(0, 199) != 0);
         bus.start    = ($urandom_range(0, 3) == 0);
         bus.hi_write = ($urandom_range(0, 5) == 0);
         bus.lo_write = ($urandom_range(0, 5) == 0);
         bus.write_data = $urandom;
         case ($urandom_range(0, 4))
            0: begin bus.dividend_in = 32'h8000_0000; bus.divisor_in = 32'hFFFF_FFFF; end
            1: begin bus.dividend_in = $urandom; bus.divisor_in = 0; end
            2: begin bus.dividend_in = $urandom_range(0, 2000) - 1000; bus.divisor_in = $urandom_range(1, 40) - 20; end
            default: begin bus.dividend_in = $urandom; bus.divisor_in = $urandom; end
         endcase
      end
      @(negedge clk);
      clr = 1;
      idle_inputs();
      repeat (S + 3) @(negedge clk);
      cmp_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/div_hilo_unit.md
Name: div_hilo_unit

Overview:
- Sequential control stage wrapped around the combinational array divider.
- Registers the operands that drive the divider's dividend/divisor inputs, waits a fixed settle window for the long array path, then captures quotient/remainder into the LO/HI registers.
- Provides a start/busy/done handshake to the control unit and direct HI/LO writes for move-to-HI/LO instructions.

Parameters:
- BITS, 32, operand/result width.
- SETTLE_CYCLES, 4, clock edges between operand registration and result capture; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous active-low reset.
- start  input  1  request a divide; sampled on rising clk.
- dividend_in  input  BITS  signed dividend, sampled with start.
- divisor_in  input  BITS  signed divisor, sampled with start.
- div_dividend  output  BITS  registered operand driving the divider's dividend input.
- div_divisor  output  BITS  registered operand driving the divider's divisor input.
- div_quotient  input  BITS  quotient returned by the divider.
- div_remainder  input  BITS  remainder returned by the divider.
- hi_write  input  1  load write_data into HI.
- lo_write  input  1  load write_data into LO.
- write_data  input  BITS  data for hi_write/lo_write.
- busy  output  1  divide in progress.
- done  output  1  one-cycle pulse when HI/LO hold a new divide result.
- div_zero  output  1  last divide had a zero divisor; sticky until the next accepted start or reset.
- hi_out  output  BITS  HI register (remainder).
- lo_out  output  BITS  LO register (quotient).

Behaviour:
- Reset (clr low, asynchronous): state IDLE; counter 0; div_dividend, div_divisor, hi_out, lo_out = 0; busy, done, div_zero = 0.
- States:
  - IDLE:
    - start=1 at edge E0: latch dividend_in/divisor_in into div_dividend/div_divisor, clear div_zero, load counter = SETTLE_CYCLES-1, go to SETTLE.
    - Otherwise hi_write/lo_write are honoured.
  - SETTLE:
    - busy=1; counter decrements each edge.
    - On the edge where counter = 0, capture div_quotient into LO and div_remainder into HI, then go to DONE.
    - Result is captured at edge E0+SETTLE_CYCLES.
  - DONE:
    - done=1 and busy=0 for exactly one cycle.
    - Behaves as IDLE: start in DONE is accepted identically and re-enters SETTLE; done still deasserts after that one cycle.
- Handshake and write rules:
  - start while in SETTLE is ignored; no queuing.
  - hi_write/lo_write in SETTLE are ignored; HI/LO are owned by the divide in progress.
  - start together with hi_write/lo_write in IDLE/DONE: start accepted, writes discarded.
  - hi_write and lo_write together: both registers load write_data.
- Operands: div_dividend/div_divisor hold their value through SETTLE and afterwards until the next accepted start; the divider inputs never glitch mid-divide.
- Arithmetic: the block performs no arithmetic. Results are the divider's C semantics (quotient truncates toward zero, remainder takes the dividend's sign); the block passes them through bit-exact.
- Corner case: most-negative / -1 yields whatever the divider produces; no special-casing.
- Reset mid-SETTLE: abort immediately, all outputs return to reset values, no done pulse.

Optional Feature:
- Macro: DIV_HILO_ZERO_TRAP_EN.
- Defined:
  - On accepted start with divisor_in == 0, skip SETTLE and go straight to DONE on the next edge (latency 1).
  - LO = all ones, HI = dividend_in, div_zero = 1.
  - div_dividend/div_divisor are still latched.
- Undefined:
  - Zero divisors take the normal SETTLE path and capture the divider's outputs unchanged.
  - div_zero is tied to 0.

Test Plan:
- Basic divide: start with 97 / 7, SETTLE_CYCLES=4 -> busy high for 4 cycles; done pulses once; lo_out=13, hi_out=6; busy=0 and done=0 afterwards.
- Signed divide: -97 / 7 -> lo_out=-13, hi_out=-6. Then 97 / -7 -> lo_out=-13, hi_out=6.
- Ignored requests during SETTLE: start with 1000 / 3, then start with 5 / 5 and hi_write with 0xDEAD two cycles later -> both ignored; lo_out=333, hi_out=1; div_dividend stays 1000 throughout.
- Back-to-back divides: start asserted in the DONE cycle with 50 / 8 -> accepted; a second done pulse after 4 more cycles; lo_out=6, hi_out=2.
- Reset mid-divide: clr low two cycles into SETTLE -> hi_out, lo_out, busy, done all 0 immediately; no done pulse follows. Then hi_write=1, lo_write=1, write_data=0x1234 -> both registers read 0x1234.
- Zero divisor with DIV_HILO_ZERO_TRAP_EN: 42 / 0 -> done one cycle after start; lo_out=0xFFFFFFFF, hi_out=42, div_zero=1. div_zero clears on the next accepted start.
